// File: rtl/spi_reg_bank.sv
// SPI Mode 0 slave register bank: control, 24-bit frequency, volume, wavetable, status.
// Optional MISO readback path enabled by defining SPI_READBACK_EN.
module spi_reg_bank #(
  parameter int         WT_DEPTH = 8,
  parameter logic [6:0] WT_BASE  = 7'h10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_mosi,
  input  logic                  spi_sck,
  input  logic                  spi_cs,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic                  status_gate_active,
  input  logic                  status_osc_running,
  output logic [7:0]            reg_control,
  output logic [23:0]           reg_freq,
  output logic [7:0]            reg_volume,
  output logic [8*WT_DEPTH-1:0] wavetable,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr
);

  localparam int         IW        = (WT_DEPTH > 1) ? $clog2(WT_DEPTH) : 1;
  localparam logic [6:0] WT_LAST   = 7'(WT_BASE + WT_DEPTH - 1);
  localparam logic [6:0] STAT_ADDR = 7'(WT_BASE + WT_DEPTH);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t      state_q, state_d;
  logic [1:0]  mosi_s, sck_s, cs_s;
  logic        sck_d;
  logic [1:0]  rst_pipe;
  logic        armed;
  logic [6:0]  shift_in;
  logic [2:0]  bit_cnt;
  logic [6:0]  addr;
  logic        wr_pend;
  logic [7:0]  wr_data;
  logic [7:0]  wt_mem [WT_DEPTH];

  logic       active, sck_rise, byte_end;
  logic [7:0] rx_byte;

  // armed only after the synchroniser has seen a real cs-high since reset
  assign active   = armed & ~cs_s[1];
  assign sck_rise = active & sck_s[1] & ~sck_d;
  assign byte_end = sck_rise & (bit_cnt == 3'd7);
  assign rx_byte  = {shift_in, mosi_s[1]};

  function automatic logic is_wt(input logic [6:0] a);
    return (a >= WT_BASE) && (a <= WT_LAST);
  endfunction

  function automatic logic is_wr(input logic [6:0] a);
    return (a == 7'h00) || (a >= 7'h02 && a <= 7'h05) || is_wt(a);
  endfunction

  for (genvar i = 0; i < WT_DEPTH; i++) begin : g_wt
    assign wavetable[8*i +: 8] = wt_mem[i];
  end

  always_comb begin
    state_d = state_q;
    if (cs_s[1]) state_d = IDLE;
    else if (sck_rise) begin
      case (state_q)
        IDLE:    state_d = CMD;
        CMD:     if (bit_cnt == 3'd7) state_d = rx_byte[7] ? READ : WRITE;
        default: state_d = state_q;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic [7:0] tx_sh;
  logic [2:0] tx_cnt;
  logic       sck_fall;

  assign sck_fall = active & ~sck_s[1] & sck_d;
  assign spi_miso = (state_q == READ) & tx_sh[7];

  function automatic logic [7:0] rd_mux(input logic [6:0] a);
    logic [7:0] d;
    d = 8'h00;
    case (a)
      7'h00:   d = reg_control;
      7'h02:   d = reg_freq[7:0];
      7'h03:   d = reg_freq[15:8];
      7'h04:   d = reg_freq[23:16];
      7'h05:   d = reg_volume;
      default: begin
        if (a == STAT_ADDR) d = {6'b0, status_osc_running, status_gate_active};
        else if (is_wt(a))  d = wt_mem[IW'(a - WT_BASE)];
      end
    endcase
    return d;
  endfunction
`else
  logic unused_status;
  assign unused_status = status_gate_active ^ status_osc_running;
  assign spi_miso      = 1'b0;
  assign spi_miso_oe   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mosi_s      <= 2'b00;
      sck_s       <= 2'b00;
      cs_s        <= 2'b11;
      sck_d       <= 1'b0;
      rst_pipe    <= 2'b00;
      armed       <= 1'b0;
      shift_in    <= '0;
      bit_cnt     <= '0;
      addr        <= '0;
      wr_pend     <= 1'b0;
      wr_data     <= '0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      reg_control <= 8'h00;
      reg_freq    <= 24'h000000;
      reg_volume  <= 8'hFF;
      for (int i = 0; i < WT_DEPTH; i++) wt_mem[i] <= 8'((i * 255) / (WT_DEPTH - 1));
`ifdef SPI_READBACK_EN
      tx_sh       <= '0;
      tx_cnt      <= '0;
      spi_miso_oe <= 1'b0;
`endif
    end else begin
      mosi_s    <= {mosi_s[0], spi_mosi};
      sck_s     <= {sck_s[0], spi_sck};
      cs_s      <= {cs_s[0], spi_cs};
      sck_d     <= sck_s[1];
      rst_pipe  <= {rst_pipe[0], 1'b1};
      if (rst_pipe[1] && cs_s[1]) armed <= 1'b1;
      state_q   <= state_d;
      wr_strobe <= 1'b0;

      // a completed byte commits one clk later, even if cs rises meanwhile
      if (wr_pend) begin
        wr_pend <= 1'b0;
        addr    <= addr + 7'd1;
        if (is_wr(addr)) begin
          wr_strobe <= 1'b1;
          wr_addr   <= addr;
          case (addr)
            7'h00:   reg_control       <= wr_data;
            7'h02:   reg_freq[7:0]     <= wr_data;
            7'h03:   reg_freq[15:8]    <= wr_data;
            7'h04:   reg_freq[23:16]   <= wr_data;
            7'h05:   reg_volume        <= wr_data;
            default: wt_mem[IW'(addr - WT_BASE)] <= wr_data;
          endcase
        end
      end

      if (cs_s[1]) bit_cnt <= '0;
      else if (sck_rise) begin
        shift_in <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (state_q == CMD && bit_cnt == 3'd7) addr <= rx_byte[6:0];
        if (state_q == WRITE && byte_end) begin
          wr_pend <= 1'b1;
          wr_data <= rx_byte;
        end
      end

`ifdef SPI_READBACK_EN
      spi_miso_oe <= ~cs_s[1];
      if (cs_s[1] || state_q != READ) tx_cnt <= '0;
      else if (sck_fall) begin
        tx_cnt <= tx_cnt + 3'd1;
        if (tx_cnt == 3'd0) begin
          tx_sh <= rd_mux(addr);
          addr  <= addr + 7'd1;
        end else tx_sh <= {tx_sh[6:0], 1'b0};
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: table-driven single writes plus burst,
// readback, status, abort, wrap, reset-mid-transfer and WT_DEPTH=16 sequences.
module tb_spi_reg_bank;

  logic clk = 1'b0, rst_n = 1'b0;
  logic mosi = 1'b0, sck = 1'b0, cs = 1'b1;
  logic gate = 1'b0, osc = 1'b0;

  logic        miso0, oe0, stb0;
  logic [6:0]  wa0;
  logic [7:0]  ctrl0, vol0;
  logic [23:0] freq0;
  logic [63:0] wt0;

  logic        miso1, oe1, stb1;
  logic [6:0]  wa1;
  logic [7:0]  ctrl1, vol1;
  logic [23:0] freq1;
  logic [127:0] wt1;

  always #5 clk = ~clk;

  spi_reg_bank dut0 (
    .clk(clk), .rst_n(rst_n), .spi_mosi(mosi), .spi_sck(sck), .spi_cs(cs),
    .spi_miso(miso0), .spi_miso_oe(oe0),
    .status_gate_active(gate), .status_osc_running(osc),
    .reg_control(ctrl0), .reg_freq(freq0), .reg_volume(vol0), .wavetable(wt0),
    .wr_strobe(stb0), .wr_addr(wa0)
  );

  spi_reg_bank #(.WT_DEPTH(16), .WT_BASE(7'h20)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi_mosi(mosi), .spi_sck(sck), .spi_cs(cs),
    .spi_miso(miso1), .spi_miso_oe(oe1),
    .status_gate_active(gate), .status_osc_running(osc),
    .reg_control(ctrl1), .reg_freq(freq1), .reg_volume(vol1), .wavetable(wt1),
    .wr_strobe(stb1), .wr_addr(wa1)
  );

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    bit         wr;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m [128];
  logic [6:0] exp_q [$];
  logic [6:0] obs_q [$];
  vec_t       vecs [8];

`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  always @(negedge clk) if (stb0) obs_q.push_back(wa0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m[i] = 8'h00;
    m[5] = 8'hFF;
    for (int i = 0; i < 8; i++) m[16+i] = 8'((i * 255) / 7);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #40;
      rx[i] = miso0;
      sck = 1'b1;
      #40;
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] rx);
    spi_bits(b, 8, rx);
  endtask

  task automatic cs_lo();
    cs = 1'b0;
    #80;
  endtask

  task automatic cs_hi();
    #80;
    cs = 1'b1;
    #100;
  endtask

  task automatic write1(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rx;
    cs_lo();
    spi_byte({1'b0, a}, rx);
    spi_byte(d, rx);
    cs_hi();
  endtask

  task automatic read1(input logic [6:0] a, output logic [7:0] rx);
    logic [7:0] dummy;
    cs_lo();
    spi_byte({1'b1, a}, dummy);
    spi_byte(8'h00, rx);
    cs_hi();
  endtask

  task automatic check_regs(input string tag);
    logic [63:0] wexp;
    for (int i = 0; i < 8; i++) wexp[8*i +: 8] = m[16+i];
    chk({tag, "_ctrl"}, 64'(ctrl0), 64'(m[0]));
    chk({tag, "_freq"}, 64'(freq0), 64'({m[4], m[3], m[2]}));
    chk({tag, "_vol"},  64'(vol0),  64'(m[5]));
    chk({tag, "_wt"},   wt0, wexp);
  endtask

  task automatic check_strobes(input string tag);
    chk({tag, "_nstrobe"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_wr_addr"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx;
    logic [7:0] dummy;

    vecs[0] = '{7'h00, 8'h5A, 1'b1};
    vecs[1] = '{7'h01, 8'h77, 1'b0};
    vecs[2] = '{7'h05, 8'h3C, 1'b1};
    vecs[3] = '{7'h10, 8'hEE, 1'b1};
    vecs[4] = '{7'h17, 8'h01, 1'b1};
    vecs[5] = '{7'h18, 8'hFF, 1'b0};
    vecs[6] = '{7'h40, 8'h99, 1'b0};
    vecs[7] = '{7'h7E, 8'h12, 1'b0};

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vol", 64'(vol0), 64'hFF);
    chk("rst_freq", 64'(freq0), 64'h0);
    chk("rst_ctrl", 64'(ctrl0), 64'h0);
    chk("rst_wt1", 64'(wt0[15:8]), 64'd36);
    chk("rst_wt7", 64'(wt0[63:56]), 64'd255);
    chk("rst_miso", 64'(miso0), 64'h0);
    chk("rst_oe", 64'(oe0), 64'h0);
    chk("rst_strobe", 64'(stb0), 64'h0);
    chk("rst_wr_addr", 64'(wa0), 64'h0);
    chk("rst_d16_wt15", 64'(wt1[127:120]), 64'd255);
    chk("rst_d16_wt1", 64'(wt1[15:8]), 64'd17);
    rst_n = 1'b1;
    #100;

    for (int i = 0; i < 8; i++) begin
      write1(vecs[i].addr, vecs[i].data);
      if (vecs[i].wr) begin
        m[vecs[i].addr] = vecs[i].data;
        exp_q.push_back(vecs[i].addr);
      end
      check_strobes($sformatf("vec%0d", i));
      check_regs($sformatf("vec%0d", i));
    end

    cs_lo();
    spi_byte(8'h02, dummy);
    spi_byte(8'h56, dummy);
    spi_byte(8'h34, dummy);
    spi_byte(8'h12, dummy);
    cs_hi();
    m[2] = 8'h56; m[3] = 8'h34; m[4] = 8'h12;
    exp_q.push_back(7'h02); exp_q.push_back(7'h03); exp_q.push_back(7'h04);
    chk("burst_freq", 64'(freq0), 64'h123456);
    check_strobes("burst");
    check_regs("burst");

    write1(7'h05, 8'hA5);
    m[5] = 8'hA5;
    exp_q.push_back(7'h05);
    check_strobes("vol_a5");
    cs_lo();
    chk("oe_cs_low", 64'(oe0), 64'(RB));
    spi_byte(8'h85, dummy);
    chk("miso_in_cmd", 64'(dummy), 64'h0);
    spi_byte(8'h00, rx);
    cs_hi();
    chk("oe_cs_high", 64'(oe0), 64'h0);
    chk("read_vol", 64'(rx), RB ? 64'hA5 : 64'h0);

    cs_lo();
    spi_byte(8'h82, dummy);
    spi_byte(8'hFF, rx);
    chk("rburst_0", 64'(rx), RB ? 64'h56 : 64'h0);
    spi_byte(8'hFF, rx);
    chk("rburst_1", 64'(rx), RB ? 64'h34 : 64'h0);
    cs_hi();
    chk("rburst_miso_idle", 64'(miso0), 64'h0);

    write1(7'h18, 8'hFF);
    osc = 1'b1; gate = 1'b0;
    read1(7'h18, rx);
    chk("read_status", 64'(rx), RB ? 64'h02 : 64'h0);
    read1(7'h01, rx);
    chk("read_unmapped", 64'(rx), 64'h00);
    read1(7'h17, rx);
    chk("read_wt7", 64'(rx), RB ? 64'h01 : 64'h0);
    check_strobes("status");
    check_regs("status");

    cs_lo();
    spi_byte(8'h05, dummy);
    spi_bits(8'h3C, 5, dummy);
    cs_hi();
    check_strobes("abort");
    check_regs("abort");

    cs_lo();
    spi_byte(8'h7F, dummy);
    spi_byte(8'h11, dummy);
    spi_byte(8'h22, dummy);
    cs_hi();
    m[0] = 8'h22;
    exp_q.push_back(7'h00);
    chk("wrap_ctrl", 64'(ctrl0), 64'h22);
    check_strobes("wrap");
    check_regs("wrap");

    write1(7'h2F, 8'h80);
    chk("d16_wt15", 64'(wt1[127:120]), 64'h80);
    check_strobes("d16");
    check_regs("d16");

    cs_lo();
    spi_bits(8'h05, 4, dummy);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #40;
    spi_byte(8'h05, dummy);
    spi_byte(8'h3C, dummy);
    cs_hi();
    check_strobes("rst_mid");
    check_regs("rst_mid");
    write1(7'h05, 8'h3C);
    m[5] = 8'h3C;
    exp_q.push_back(7'h05);
    check_strobes("post_rst");
    check_regs("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter WT_DEPTH, default 8, wavetable sample count; legal values 2,4,8,16,32.
REQ-002 SHALL have parameter WT_BASE, default 7'h10, wavetable base address; WT_BASE+WT_DEPTH SHALL be <= 7'h7F.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports spi_mosi, spi_sck, spi_cs  input  1 each  SPI Mode 0 pins; spi_cs active low.
REQ-006 SHALL have port spi_miso  output  1  serial read data.
REQ-007 SHALL have port spi_miso_oe  output  1  MISO pad enable, high only while spi_cs is synchronised low.
REQ-008 SHALL have ports status_gate_active, status_osc_running  input  1 each  status sources.
REQ-009 SHALL have port reg_control  output  8  register 0x00.
REQ-010 SHALL have port reg_freq  output  24  registers 0x02 (bits 7:0), 0x03 (bits 15:8), 0x04 (bits 23:16).
REQ-011 SHALL have port reg_volume  output  8  register 0x05.
REQ-012 SHALL have port wavetable  output  8*WT_DEPTH  sample i on bits 8i+7:8i, address WT_BASE+i.
REQ-013 SHALL have ports wr_strobe  output  1  and  wr_addr  output  7  one-cycle pulse plus address of each committed write.

Function
REQ-014 SHALL pass mosi, sck and cs through 2-flop synchronisers, cs flops resetting to 1; SCK edges detected on the synchronised signal; SCK frequency SHALL be <= clk/8.
REQ-015 SHALL use states IDLE, CMD, WRITE, READ; cs high forces IDLE, bit counter 0, miso_oe 0 on the next clk, aborting any partial byte without a register write.
REQ-016 SHALL shift MOSI in MSB-first on synchronised SCK rising edges; first rising edge with cs low moves IDLE->CMD.
REQ-017 SHALL treat the first byte as command {rw, addr[6:0]}: rw=0 -> WRITE, rw=1 -> READ, address latched after the 8th bit.
REQ-018 SHALL commit each complete WRITE byte to the latched address in the clk after the 8th rising edge, pulse wr_strobe/wr_addr in that cycle, then increment the address.
REQ-019 SHALL increment addresses modulo 128 (7'h7F -> 7'h00) in both WRITE and READ bursts.
REQ-020 SHALL ignore writes to the status address WT_BASE+WT_DEPTH and to unmapped addresses: no register change, no wr_strobe.
REQ-021 SHALL, in READ, load the addressed register into a TX shift register on the SCK falling edge following the 8th command bit, driving its MSB on spi_miso; each later falling edge shifts the next bit; after 8 bits it reloads from the incremented address.
REQ-022 SHALL return {6'b0, status_osc_running, status_gate_active} for the status address and 8'h00 for unmapped reads, sampled at TX load.
REQ-023 SHALL drive spi_miso 0 whenever not in READ.
REQ-024 SHALL ignore MOSI data bits during READ bursts.

Reset
REQ-025 SHALL, with rst_n low at a clk edge, set reg_control=8'h00, reg_freq=24'h000000, reg_volume=8'hFF, wr_strobe=0, wr_addr=0, spi_miso=0, spi_miso_oe=0, state IDLE.
REQ-026 SHALL reset wavetable sample i to floor(i*255/(WT_DEPTH-1)) (sawtooth; depth 8 gives 0,36,72,109,145,182,218,255).
REQ-027 SHALL, on reset mid-transfer, discard the partial byte; the transfer resumes only after cs high then low.

Configuration
REQ-028 SHALL honour macro SPI_READBACK_EN: defined -> READ state and MISO path per REQ-021..REQ-023; undefined -> no TX logic, spi_miso and spi_miso_oe tied 0, rw=1 commands consume bytes with no register effect.

Verification
REQ-029 SHALL cover reset: after rst_n low, reg_volume=8'hFF, reg_freq=0, wavetable[15:8]=8'd36 (WT_DEPTH=8).
REQ-030 SHALL cover write burst: cs low, bytes 0x02,0x56,0x34,0x12 -> reg_freq=24'h123456, three wr_strobe pulses with wr_addr 2,3,4.
REQ-031 SHALL cover readback (SPI_READBACK_EN): write 0x05=0xA5, then bytes 0x85,0x00 -> MISO carries 0xA5 MSB-first.
REQ-032 SHALL cover status/unmapped: write 0x18=0xFF -> no strobe; read 0x98 with osc_running=1, gate_active=0 -> 0x02; read 0x81 -> 0x00.
REQ-033 SHALL cover abort and wrap: cs high after 5 data bits -> no change; burst write at 0x7F, 0x00 with bytes 0x11,0x22 -> reg_control=0x22.
REQ-034 SHALL cover WT_DEPTH=16, WT_BASE=7'h20: write 0x2F=0x80 -> wavetable[127:120]=0x80, sample 15 reset value 255.
